// File: rtl/muldiv_unit_if.sv
// Request/response bundle between the execute-stage control and the M-extension unit.
interface muldiv_unit_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [2:0]      in_funct3;
    logic [XLEN-1:0] in_a;
    logic [XLEN-1:0] in_b;
    logic            kill;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_result;
    logic            busy;

    modport master (
        output in_valid, in_funct3, in_a, in_b, kill, out_ready,
        input  in_ready, out_valid, out_result, busy
    );

    modport slave (
        input  in_valid, in_funct3, in_a, in_b, kill, out_ready,
        output in_ready, out_valid, out_result, busy
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring divide on
// magnitudes, BITS_PER_CYCLE bits per iteration, sign fix-up on the final step.
module muldiv_unit #(
    parameter int XLEN           = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic        clk,
    input  logic        reset,
    muldiv_unit_if.slave bus
);
    localparam int ITER = XLEN / BITS_PER_CYCLE;
    localparam int CW   = $clog2(ITER + 1);
    localparam int BPC  = BITS_PER_CYCLE;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t          state_reg, state_next;
    logic [CW-1:0]   cnt_reg;
    logic [2:0]      op_reg;
    logic            neg_q_reg, neg_r_reg;
    logic [XLEN-1:0] opnd_reg, hi_reg, lo_reg, result_reg;

    // Operand decode at accept
    logic            accept, is_div, a_signed, b_signed, neg_a, neg_b;
    logic            div_zero, div_ovf, special;
    logic [XLEN-1:0] mag_a, mag_b, special_res;
    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    assign accept   = bus.in_valid && (state_reg == IDLE) && !bus.kill;
    assign is_div   = bus.in_funct3[2];
    assign a_signed = is_div ? !bus.in_funct3[0] : (bus.in_funct3[1:0] != 2'b11);
    assign b_signed = is_div ? !bus.in_funct3[0] : !bus.in_funct3[1];
    assign neg_a    = a_signed && bus.in_a[XLEN-1];
    assign neg_b    = b_signed && bus.in_b[XLEN-1];
    assign mag_a    = neg_a ? -bus.in_a : bus.in_a;
    assign mag_b    = neg_b ? -bus.in_b : bus.in_b;
    assign div_zero = is_div && (bus.in_b == '0);
    assign div_ovf  = is_div && !bus.in_funct3[0] && (bus.in_a == MOST_NEG) && (bus.in_b == '1);
    assign special  = div_zero || div_ovf;
    assign special_res = bus.in_funct3[1] ? (div_zero ? bus.in_a : '0)
                                          : (div_zero ? '1 : bus.in_a);

    // Multiply step: add digit*multiplicand to the high half, shift the pair right
    logic [BPC-1:0]      digit;
    logic [XLEN+BPC-1:0] pp, mul_sum;
    logic [XLEN-1:0]     mul_hi, mul_lo;

    assign digit   = lo_reg[BPC-1:0];
    assign pp      = {{BPC{1'b0}}, opnd_reg} * {{XLEN{1'b0}}, digit};
    assign mul_sum = pp + {{BPC{1'b0}}, hi_reg};
    assign mul_hi  = mul_sum[XLEN+BPC-1:BPC];
    assign mul_lo  = {mul_sum[BPC-1:0], lo_reg[XLEN-1:BPC]};

    // Restoring divide chain: hi holds the partial remainder, lo shifts dividend out / quotient in
    genvar gi;
    generate
        for (gi = 0; gi < BPC; gi++) begin : g_div
            logic [XLEN-1:0] rem_in, quo_in, rem_out, quo_out, shifted;
            logic [XLEN:0]   diff;
            if (gi == 0) begin : g_first
                assign rem_in = hi_reg;
                assign quo_in = lo_reg;
            end else begin : g_chain
                assign rem_in = g_div[gi-1].rem_out;
                assign quo_in = g_div[gi-1].quo_out;
            end
            assign shifted = {rem_in[XLEN-2:0], quo_in[XLEN-1]};
            assign diff    = {rem_in[XLEN-1], shifted} - {1'b0, opnd_reg};
            assign rem_out = diff[XLEN] ? shifted : diff[XLEN-1:0];
            assign quo_out = {quo_in[XLEN-2:0], ~diff[XLEN]};
        end
    endgenerate

    logic [XLEN-1:0]   hi_step, lo_step, quo_fix, rem_fix, result_next;
    logic [2*XLEN-1:0] prod, prod_fix;

    assign hi_step  = op_reg[2] ? g_div[BPC-1].rem_out : mul_hi;
    assign lo_step  = op_reg[2] ? g_div[BPC-1].quo_out : mul_lo;
    assign prod     = {hi_step, lo_step};
    assign prod_fix = neg_q_reg ? -prod : prod;
    assign quo_fix  = neg_q_reg ? -lo_step : lo_step;
    assign rem_fix  = neg_r_reg ? -hi_step : hi_step;

    always_comb begin
        result_next = '0;
        if (op_reg[2])
            result_next = op_reg[1] ? rem_fix : quo_fix;
        else if (op_reg[1:0] == 2'b00)
            result_next = prod_fix[XLEN-1:0];
        else
            result_next = prod_fix[2*XLEN-1:XLEN];
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset)
            state_reg <= IDLE;
        else
            state_reg <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (accept) state_next = special ? DONE : BUSY;
            BUSY: begin
                if (bus.kill)
                    state_next = IDLE;
                else if (cnt_reg == CW'(1))
                    state_next = DONE;
            end
            DONE: if (bus.kill || bus.out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        bus.in_ready   = (state_reg == IDLE);
        bus.out_valid  = (state_reg == DONE);
        bus.busy       = (state_reg != IDLE);
        bus.out_result = result_reg;
    end

    // Datapath
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_reg    <= '0;
            op_reg     <= '0;
            neg_q_reg  <= 1'b0;
            neg_r_reg  <= 1'b0;
            opnd_reg   <= '0;
            hi_reg     <= '0;
            lo_reg     <= '0;
            result_reg <= '0;
        end else if (accept) begin
            cnt_reg   <= CW'(ITER);
            op_reg    <= bus.in_funct3;
            neg_q_reg <= neg_a ^ neg_b;
            neg_r_reg <= neg_a;
            opnd_reg  <= is_div ? mag_b : mag_a;
            lo_reg    <= is_div ? mag_a : mag_b;
            hi_reg    <= '0;
            if (special)
                result_reg <= special_res;
        end else if (state_reg == BUSY && !bus.kill) begin
            hi_reg  <= hi_step;
            lo_reg  <= lo_step;
            cnt_reg <= cnt_reg - CW'(1);
            if (cnt_reg == CW'(1))
                result_reg <= result_next;
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: directed vectors on a radix-2 instance, random ops on a radix-16
// instance, every output cycle checked against an arithmetic reference model.
module tb_muldiv_unit;
    localparam logic [31:0] MOST_NEG = 32'h8000_0000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst1, rst4;
    int   cyc = 0;
    int   n_total = 0;
    int   n_pass  = 0;

    muldiv_unit_if #(.XLEN(32)) b1();
    muldiv_unit_if #(.XLEN(32)) b4();

    muldiv_unit #(.XLEN(32), .BITS_PER_CYCLE(1)) dut1 (.clk(clk), .reset(rst1), .bus(b1));
    muldiv_unit #(.XLEN(32), .BITS_PER_CYCLE(4)) dut4 (.clk(clk), .reset(rst4), .bus(b4));

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    // Reference: plain 64-bit arithmetic following the RISC-V M rules
    function automatic logic [31:0] ref_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        longint          sa, sb;
        longint unsigned ua, ub;
        logic [63:0]     p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        case (f)
            3'd0: begin p = ua * ub; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * longint'(ub); return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == MOST_NEG && b == 32'hFFFF_FFFF) return a;
                p = sa / sb; return p[31:0];
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == MOST_NEG && b == 32'hFFFF_FFFF) return 32'h0;
                p = sa % sb; return p[31:0];
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int ref_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input int iter);
        if (f[2] && (b == 0 || (!f[0] && a == MOST_NEG && b == 32'hFFFF_FFFF)))
            return 1;
        return iter + 1;
    endfunction

    // Scoreboard state per instance (0 = radix 2, 1 = radix 16)
    bit          pend[2];
    bit          seen[2];
    logic [31:0] ev[2];
    int          el[2];
    int          acc[2];

    task automatic mon(input int i, input int iter, input logic rst, input logic kill,
                       input logic iv, input logic ir, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] b, input logic ov,
                       input logic ordy, input logic [31:0] res);
        if (pend[i]) begin
            if (ov) begin
                if (!seen[i]) begin
                    seen[i] = 1'b1;
                    check($sformatf("dut%0d latency", i), 32'(cyc - acc[i]), 32'(el[i]));
                    $display("dut%0d result=%08h expect=%08h lat=%0d", i, res, ev[i], cyc - acc[i]);
                end
                check($sformatf("dut%0d result", i), res, ev[i]);
                check($sformatf("dut%0d in_ready in DONE", i), {31'b0, ir}, 32'd0);
            end else if (cyc - acc[i] >= el[i]) begin
                check($sformatf("dut%0d valid by deadline", i), {31'b0, ov}, 32'd1);
                pend[i] = 1'b0;
            end
        end else if (ov) begin
            check($sformatf("dut%0d spurious out_valid", i), {31'b0, ov}, 32'd0);
        end
        if (rst || (kill && pend[i]))
            pend[i] = 1'b0;
        else if (ov && ordy)
            pend[i] = 1'b0;
        if (!rst && iv && ir && !kill) begin
            pend[i] = 1'b1;
            seen[i] = 1'b0;
            ev[i]   = ref_op(f3, a, b);
            el[i]   = ref_lat(f3, a, b, iter);
            acc[i]  = cyc;
            $display("dut%0d accept f3=%0d a=%08h b=%08h", i, f3, a, b);
        end
    endtask

    always @(negedge clk) begin
        mon(0, 32, rst1, b1.kill, b1.in_valid, b1.in_ready, b1.in_funct3, b1.in_a, b1.in_b,
            b1.out_valid, b1.out_ready, b1.out_result);
        mon(1, 8, rst4, b4.kill, b4.in_valid, b4.in_ready, b4.in_funct3, b4.in_a, b4.in_b,
            b4.out_valid, b4.out_ready, b4.out_result);
    end

    task automatic check_reset1(input string tag);
        check({tag, " in_ready"},  {31'b0, b1.in_ready},  32'd1);
        check({tag, " out_valid"}, {31'b0, b1.out_valid}, 32'd0);
        check({tag, " out_result"}, b1.out_result, 32'd0);
        check({tag, " busy"},      {31'b0, b1.busy},      32'd0);
    endtask

    // One directed op on the radix-2 instance; called #1 after a rising edge with the unit idle
    task automatic op1(input string name, input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
        int lat;
        bit got;
        b1.in_funct3 = f; b1.in_a = a; b1.in_b = b; b1.in_valid = 1'b1; b1.out_ready = 1'b1;
        @(posedge clk); #1;
        b1.in_valid = 1'b0; b1.in_a = $urandom; b1.in_b = $urandom;
        lat = 1; got = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (b1.out_valid) begin got = 1'b1; break; end
            lat++;
        end
        check({name, " valid"}, {31'b0, got}, 32'd1);
        if (got) begin
            check(name, b1.out_result, exp);
            check({name, " latency"}, 32'(lat), 32'(exp_lat));
        end
        @(posedge clk); #1;
    endtask

    task automatic start1(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        b1.in_funct3 = f; b1.in_a = a; b1.in_b = b; b1.in_valid = 1'b1;
        @(posedge clk); #1;
        b1.in_valid = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] ra, rb;
        logic [2:0]  rf;
        int          k;

        rst1 = 1'b1; rst4 = 1'b1;
        b1.in_valid = 0; b1.in_funct3 = 0; b1.in_a = 0; b1.in_b = 0; b1.kill = 0; b1.out_ready = 1;
        b4.in_valid = 0; b4.in_funct3 = 0; b4.in_a = 0; b4.in_b = 0; b4.kill = 0; b4.out_ready = 1;

        check("model MUL",  ref_op(3'd0, 32'd7, 32'hFFFF_FFFD), 32'hFFFF_FFEB);
        check("model MULH", ref_op(3'd1, MOST_NEG, MOST_NEG), 32'h4000_0000);
        check("model DIV",  ref_op(3'd4, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFD);
        check("model REM",  ref_op(3'd6, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFF);

        repeat (3) @(posedge clk); #1;
        check_reset1("reset");
        check("dut4 reset busy", {31'b0, b4.busy}, 32'd0);
        rst1 = 1'b0; rst4 = 1'b0;
        @(posedge clk); #1;

        op1("MUL 7*-3",        3'd0, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, 33);
        op1("MULH min*min",    3'd1, MOST_NEG,     MOST_NEG,      32'h4000_0000, 33);
        op1("MULHU max*max",   3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
        op1("MULHSU -1*2",     3'd2, 32'hFFFF_FFFF, 32'd2,        32'hFFFF_FFFF, 33);
        op1("DIV -7/2",        3'd4, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, 33);
        op1("REM -7/2",        3'd6, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 33);
        op1("DIVU 100/7",      3'd5, 32'd100,      32'd7,         32'd14,        33);
        op1("REMU 100/7",      3'd7, 32'd100,      32'd7,         32'd2,         33);
        op1("DIV x/0",         3'd4, 32'h55,       32'd0,         32'hFFFF_FFFF, 1);
        op1("REMU 0x1234/0",   3'd7, 32'h1234,     32'd0,         32'h1234,      1);
        op1("DIV min/-1",      3'd4, MOST_NEG,     32'hFFFF_FFFF, MOST_NEG,      1);
        op1("REM min/-1",      3'd6, MOST_NEG,     32'hFFFF_FFFF, 32'd0,         1);

        // Backpressure
        b1.out_ready = 1'b0;
        start1(3'd0, 32'd3, 32'd5);
        k = 0;
        while (!b1.out_valid && k < 100) begin @(negedge clk); k++; end
        check("bp valid reached", {31'b0, b1.out_valid}, 32'd1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp out_valid held", {31'b0, b1.out_valid}, 32'd1);
            check("bp out_result held", b1.out_result, 32'd15);
            check("bp in_ready low", {31'b0, b1.in_ready}, 32'd0);
        end
        @(posedge clk); #1;
        b1.out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp consumed", {31'b0, b1.out_valid}, 32'd0);

        // Kill mid-operation at T+5
        start1(3'd5, 32'd1000, 32'd3);
        repeat (4) @(posedge clk); #1;
        b1.kill = 1'b1;
        @(posedge clk); #1;
        b1.kill = 1'b0;
        check("kill in_ready", {31'b0, b1.in_ready}, 32'd1);
        check("kill busy", {31'b0, b1.busy}, 32'd0);
        check("kill out_result kept", b1.out_result, 32'd15);
        repeat (40) @(posedge clk); #1;
        check("kill no result", {31'b0, b1.out_valid}, 32'd0);

        // Kill in IDLE blocks a same-cycle accept
        b1.in_funct3 = 3'd0; b1.in_a = 32'd2; b1.in_b = 32'd2; b1.in_valid = 1'b1; b1.kill = 1'b1;
        @(posedge clk); #1;
        b1.in_valid = 1'b0; b1.kill = 1'b0;
        check("idle kill busy", {31'b0, b1.busy}, 32'd0);

        // Kill in DONE discards a held result
        b1.out_ready = 1'b0;
        start1(3'd4, 32'd9, 32'd0);
        check("done before kill", {31'b0, b1.out_valid}, 32'd1);
        b1.kill = 1'b1;
        @(posedge clk); #1;
        b1.kill = 1'b0; b1.out_ready = 1'b1;
        check("done kill out_valid", {31'b0, b1.out_valid}, 32'd0);

        // Reset mid-operation at T+10
        start1(3'd0, 32'h1234, 32'h5678);
        repeat (9) @(posedge clk); #1;
        rst1 = 1'b1;
        @(posedge clk); #1;
        rst1 = 1'b0;
        check_reset1("mid-op reset");
        repeat (40) @(posedge clk); #1;
        check("reset no result", {31'b0, b1.out_valid}, 32'd0);

        // Random ops on the radix-16 instance with random backpressure
        for (int n = 0; n < 1000; n++) begin
            k = 0;
            while (!b4.in_ready && k < 60) begin
                b4.out_ready = ($urandom_range(0, 3) != 0);
                @(posedge clk); #1;
                k++;
            end
            if (!b4.in_ready) check("dut4 in_ready timeout", {31'b0, b4.in_ready}, 32'd1);
            rf = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 7))
                0: ra = 32'd0;
                1: ra = MOST_NEG;
                2: ra = 32'hFFFF_FFFF;
                3: ra = 32'($urandom_range(0, 20));
                default: ra = $urandom;
            endcase
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: rb = 32'hFFFF_FFFF;
                2: rb = MOST_NEG;
                3: rb = 32'($urandom_range(1, 20));
                default: rb = $urandom;
            endcase
            b4.in_funct3 = rf; b4.in_a = ra; b4.in_b = rb; b4.in_valid = 1'b1;
            b4.out_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk); #1;
            b4.in_valid = 1'b0;
        end
        b4.out_ready = 1'b1;
        repeat (20) @(posedge clk); #1;
        check("dut4 drained", {31'b0, b4.busy}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative RV32M multiply/divide execution unit, parametrised in operand width and radix.
- Extends the core's single-cycle ALU path with the eight M-extension operations, selected by funct3.
- Sits beside the ALU in the execute stage; the control unit holds the pipeline via a valid/ready handshake while the unit is busy.
- Multi-cycle: one operation in flight, result buffered until consumed.

Parameters:
- XLEN, 32, operand and result width in bits (must be even, >= 8).
- BITS_PER_CYCLE, 1, quotient/product bits resolved per iteration cycle; one of 1, 2, 4; must divide XLEN.
- ITER, XLEN/BITS_PER_CYCLE, derived localparam, iteration count (not overridable).

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  operation request
- in_ready  out  1  unit can accept an operation
- in_funct3  in  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- in_a  in  XLEN  rs1 operand (multiplicand / dividend)
- in_b  in  XLEN  rs2 operand (multiplier / divisor)
- kill  in  1  abort in-flight operation (pipeline flush)
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- out_result  out  XLEN  result word
- busy  out  1  high in BUSY or DONE

Behaviour:
- Reset: state=IDLE, in_ready=1, out_valid=0, out_result=0, busy=0, all internal accumulators cleared.
- Reset has priority over every other input, including mid-operation; the in-flight operation is discarded with no output.
- FSM states: IDLE, BUSY, DONE.
- IDLE: in_ready=1. in_valid&&in_ready at edge T latches operands and funct3.
  - Special case detected: next state DONE, out_valid at T+1.
  - Otherwise: next state BUSY with counter=ITER.
- BUSY: each cycle resolves BITS_PER_CYCLE bits and decrements the counter.
  - Counter reaching 0 moves to DONE; sign fix-up is applied combinationally on that transition.
  - out_valid first high at cycle T+ITER+1 (33 for XLEN=32, radix 1; 9 for BITS_PER_CYCLE=4).
- DONE: out_valid=1, out_result stable.
  - out_ready=1: back to IDLE next cycle.
  - Otherwise the result holds indefinitely (backpressure).
  - in_ready=0 in DONE; no back-to-back accept in the same cycle.
- kill:
  - In BUSY or DONE: to IDLE next cycle; out_valid deasserts, no result is emitted.
  - In IDLE: ignored. kill with in_valid in the same cycle also blocks the accept.
- Multiply:
  - Operands are sign- or zero-extended per funct3 (MULHSU: a signed, b unsigned).
  - The 2*XLEN product is formed by shift-add on magnitudes, then negated if the operand signs differ.
  - MUL returns product[XLEN-1:0]; MULH/MULHSU/MULHU return product[2*XLEN-1:XLEN].
- Divide:
  - Restoring division on magnitudes.
  - Quotient is negated if the signs differ (signed ops).
  - Remainder takes the sign of the dividend.
- Special cases, 1-cycle path:
  - divisor=0: DIV/DIVU -> all ones; REM/REMU -> dividend.
  - Signed overflow (a = most negative, b = -1): DIV -> a; REM -> 0.
- Operand inputs are sampled only at accept; later changes have no effect.
- out_result retains its last value while not valid; consumers must qualify it with out_valid.

Test Plan:
- MUL 7 * 0xFFFFFFFD (-3), out_ready=1 -> 0xFFFFFFEB; out_valid exactly at T+33 (XLEN=32, radix 1).
- MULH 0x80000000*0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF*0x00000002 -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9 (-7) / 2 -> 0xFFFFFFFD; REM -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU -> 2.
- Special cases:
  - DIV x/0 -> 0xFFFFFFFF at T+1.
  - REMU 0x1234/0 -> 0x1234.
  - DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM -> 0.
- Backpressure and abort:
  - out_ready=0 for 10 cycles -> out_valid and out_result held, in_ready=0.
  - kill at T+5 -> IDLE at T+6, no out_valid.
  - reset at T+10 -> all outputs at reset values next cycle.
- BITS_PER_CYCLE=4 instance: randomised 1000 ops vs reference model, each result at T+9.
